// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// A grant is held for a burst that ends on req_last, MAX_BURST beats, or an IDLE_TIMEOUT stall.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned IDLE_TIMEOUT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  output logic                            grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned BEAT_W  = $clog2(MAX_BURST + 1);
  localparam int unsigned STALL_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_d;
  logic                grant_vld_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic                pick_vld;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     cand;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                beat;
  logic                done;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((32'(rr_ptr_q) + off) % NUM_REQ);
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  assign sel_data = req_data[32'(grant_id) * DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      grant_id    <= '0;
      grant_vld   <= 1'b0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id    <= grant_id_d;
      grant_vld   <= grant_vld_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state plus write-port steering from the registered grant
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id;
    grant_vld_d  = grant_vld;
    beat_cnt_d   = beat_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    beat         = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d     = S_GRANT;
          grant_id_d  = pick_id;
          grant_vld_d = 1'b1;
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
        end
      end
      S_GRANT: begin
        req_ready[grant_id] = ~fifo_full;
        beat                = req_valid[grant_id] & ~fifo_full;
        fifo_wr_en          = beat;
        if (beat) begin
          fifo_wr_data = sel_data;
          beat_cnt_d   = beat_cnt_q + BEAT_W'(1);
        end
        // Only an idle requester counts toward timeout; backpressure never does
        if (!req_valid[grant_id]) stall_cnt_d = stall_cnt_q + STALL_W'(1);
        else                      stall_cnt_d = '0;
        done = (beat & (req_last[grant_id] | (beat_cnt_q == BEAT_W'(MAX_BURST - 1))))
             | (~req_valid[grant_id] & (stall_cnt_q == STALL_W'(IDLE_TIMEOUT - 1)));
        if (done) begin
          state_d     = S_IDLE;
          grant_vld_d = 1'b0;
          rr_ptr_d    = grant_id;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin order, burst cap,
// backpressure, stall timeout and reset in the middle of a burst.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            grant_vld;
  logic [1:0]      grant_id;

  int total = 0;
  int bad   = 0;
  int full_writes = 0;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] d;
  } wr_t;
  wr_t wlog[$];

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(8), .IDLE_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_vld(grant_vld), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Record every write the fifo would take, tagged with the granted requester
  always @(posedge clk) begin
    if (fifo_wr_en) begin
      wlog.push_back({grant_id, fifo_wr_data});
      if (fifo_full) full_writes++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req_valid = '0; req_last = '0; fifo_full = 1'b0; req_data = '0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 4'hF; req_last = 4'hF; fifo_full = 1'b0;
    req_data = 32'h33221100;
    tick; tick; #1;
    total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL reset_grant_vld got=%0b exp=0", grant_vld); end
    total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0b exp=0", fifo_wr_en); end
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%h exp=0", req_ready); end
    total++; if (fifo_wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h exp=00", fifo_wr_data); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
  endtask

  task automatic test_rr_order;
    logic [1:0] id;
    do_reset;
    req_valid = 4'hF; req_last = 4'hF;
    for (int i = 0; i < 4; i++) set_data(i, 8'(8'hA0 + i));
    for (int k = 0; k < 5; k++) begin
      id = 2'(k % 4);
      tick; #1;
      total++; if (grant_vld !== 1'b1) begin bad++; $display("FAIL rr_grant_vld k=%0d got=%0b exp=1", k, grant_vld); end
      total++; if (grant_id !== id) begin bad++; $display("FAIL rr_grant_id k=%0d got=%0d exp=%0d", k, grant_id, id); end
      total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL rr_wr_en k=%0d got=%0b exp=1", k, fifo_wr_en); end
      total++; if (fifo_wr_data !== 8'(8'hA0 + id)) begin bad++; $display("FAIL rr_wr_data k=%0d got=%h exp=%h", k, fifo_wr_data, 8'(8'hA0 + id)); end
      total++; if (req_ready !== (4'b0001 << id)) begin bad++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, 4'b0001 << id); end
      tick; #1;
      total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL rr_dead_vld k=%0d got=%0b exp=0", k, grant_vld); end
      total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL rr_dead_wr_en k=%0d got=%0b exp=0", k, fifo_wr_en); end
    end
  endtask

  task automatic test_burst_cap;
    int base;
    do_reset;
    req_valid = 4'b1100; req_last = 4'b0000; set_data(3, 8'h3F);
    tick; #1;
    total++; if (grant_id !== 2'd2 || grant_vld !== 1'b1) begin bad++; $display("FAIL cap_grant got=%0d/%0b exp=2/1", grant_id, grant_vld); end
    base = wlog.size();
    for (int b = 0; b < 8; b++) begin
      set_data(2, 8'(8'h20 + b)); #1;
      total++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'(8'h20 + b)) begin bad++; $display("FAIL cap_beat b=%0d got=%0b/%h exp=1/%h", b, fifo_wr_en, fifo_wr_data, 8'(8'h20 + b)); end
      tick;
    end
    #1;
    total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL cap_release got=%0b exp=0", grant_vld); end
    total++; if (wlog.size() - base !== 8) begin bad++; $display("FAIL cap_count got=%0d exp=8", wlog.size() - base); end
    for (int b = 0; b < 8 && base + b < wlog.size(); b++) begin
      total++; if (wlog[base+b] !== {2'd2, 8'(8'h20 + b)}) begin bad++; $display("FAIL cap_log b=%0d got=%h exp=%h", b, wlog[base+b], {2'd2, 8'(8'h20 + b)}); end
    end
    tick; #1;
    total++; if (grant_id !== 2'd3 || grant_vld !== 1'b1) begin bad++; $display("FAIL cap_next got=%0d/%0b exp=3/1", grant_id, grant_vld); end
  endtask

  task automatic test_backpressure;
    int base;
    do_reset;
    req_valid = 4'b0010; req_last = 4'b0000;
    tick; #1;
    total++; if (grant_id !== 2'd1 || grant_vld !== 1'b1) begin bad++; $display("FAIL bp_grant got=%0d/%0b exp=1/1", grant_id, grant_vld); end
    base = wlog.size();
    for (int b = 0; b < 2; b++) begin
      set_data(1, 8'(8'h10 + b)); #1;
      total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL bp_pre b=%0d got=%0b exp=1", b, fifo_wr_en); end
      tick;
    end
    set_data(1, 8'h12); fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 || grant_vld !== 1'b1) begin bad++; $display("FAIL bp_full c=%0d got wr=%0b rdy=%b vld=%0b exp 0/0000/1", c, fifo_wr_en, req_ready, grant_vld); end
      tick;
    end
    fifo_full = 1'b0;
    for (int b = 2; b < 8; b++) begin
      set_data(1, 8'(8'h10 + b)); #1;
      total++; if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0010 || grant_vld !== 1'b1) begin bad++; $display("FAIL bp_post b=%0d got wr=%0b rdy=%b vld=%0b exp 1/0010/1", b, fifo_wr_en, req_ready, grant_vld); end
      tick;
    end
    #1;
    total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL bp_release got=%0b exp=0", grant_vld); end
    total++; if (wlog.size() - base !== 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", wlog.size() - base); end
    for (int b = 0; b < 8 && base + b < wlog.size(); b++) begin
      total++; if (wlog[base+b] !== {2'd1, 8'(8'h10 + b)}) begin bad++; $display("FAIL bp_log b=%0d got=%h exp=%h", b, wlog[base+b], {2'd1, 8'(8'h10 + b)}); end
    end
  endtask

  task automatic test_timeout;
    int base;
    do_reset;
    req_valid = 4'b0011; req_last = 4'b0000;
    tick; #1;
    total++; if (grant_id !== 2'd0 || grant_vld !== 1'b1) begin bad++; $display("FAIL to_grant got=%0d/%0b exp=0/1", grant_id, grant_vld); end
    base = wlog.size();
    set_data(0, 8'h01); tick;
    set_data(0, 8'h02); tick;
    // Valid drops; a last flag without valid must not end the burst
    req_valid = 4'b0010; req_last = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick; #1;
      total++; if (grant_vld !== 1'b1) begin bad++; $display("FAIL to_hold c=%0d got=%0b exp=1", c, grant_vld); end
    end
    tick; #1;
    total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL to_release got=%0b exp=0", grant_vld); end
    total++; if (wlog.size() - base !== 2) begin bad++; $display("FAIL to_count got=%0d exp=2", wlog.size() - base); end
    tick; #1;
    total++; if (grant_id !== 2'd1 || grant_vld !== 1'b1) begin bad++; $display("FAIL to_next got=%0d/%0b exp=1/1", grant_id, grant_vld); end
  endtask

  task automatic test_reset_mid;
    int base;
    do_reset;
    req_valid = 4'b0100; req_last = 4'b0000;
    tick;
    base = wlog.size();
    for (int b = 0; b < 3; b++) begin set_data(2, 8'(8'h50 + b)); tick; end
    rst_n = 1'b0; req_valid = 4'b0000;
    tick; #1;
    total++; if (grant_vld !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL rm_idle got vld=%0b wr=%0b rdy=%b exp 0/0/0000", grant_vld, fifo_wr_en, req_ready); end
    total++; if (wlog.size() - base !== 3) begin bad++; $display("FAIL rm_count got=%0d exp=3", wlog.size() - base); end
    rst_n = 1'b1; req_valid = 4'hF; req_last = 4'hF;
    tick; #1;
    total++; if (grant_id !== 2'd0 || grant_vld !== 1'b1) begin bad++; $display("FAIL rm_next got=%0d/%0b exp=0/1", grant_id, grant_vld); end
  endtask

  initial begin
    test_reset;
    test_rr_order;
    test_burst_cap;
    test_backpressure;
    test_timeout;
    test_reset_mid;
    total++; if (full_writes !== 0) begin bad++; $display("FAIL write_while_full got=%0d exp=0", full_writes); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
